uart_tx_serializer: RTL

Transmit-side stage of the UART that drains the 128x8 transmit FIFO and shifts each byte out on the serial line. It pops the FIFO through its active-low read strobe, absorbs the FIFO's two-cycle registered read latency, then frames the byte as start bit, 7/8 data bits LSB-first, optional parity and stop bit(s). Bit timing is derived from a 16x-oversampled baud tick, while all logic runs on the system clock.

---
 rtl/uart_tx_serializer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// Drains the transmit FIFO one byte at a time and shifts each byte out on
// txd as: start bit, 7 or 8 data bits LSB-first, optional parity, then
// STOP_BITS stop bits. Each bit lasts 16 pulses of baud_x16_tick. All
// logic runs on the system clock.
//
// Optional feature: define UART_TX_PARITY_EN to add the parity_en /
// parity_odd ports and the PARITY state. Without it, frames never carry
// a parity bit.
//
// Parameters:
//   STOP_BITS      stop bits per frame, 1 or 2
// Ports:
//   clock          system clock (shared with the FIFO)
//   reset_n        asynchronous active-low reset
//   baud_x16_tick  one-cycle enable at 16x the baud rate
//   fifo_data      FIFO read data, valid two clocks after the read strobe
//   fifo_empty     FIFO empty flag
//   fifo_read_n    FIFO read strobe, active low, one clock per frame
//   bit8           1 = 8 data bits, 0 = 7 data bits
//   parity_en      1 = append parity bit   (UART_TX_PARITY_EN only)
//   parity_odd     1 = odd, 0 = even parity (UART_TX_PARITY_EN only)
//   txd            serial output, idles high
//   tx_busy        high whenever the state machine is not idle
//   tx_done        one-clock pulse after the last stop bit completes
module uart_tx_serializer #(
    parameter int STOP_BITS = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       baud_x16_tick,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_read_n,
    input  logic       bit8,
`ifdef UART_TX_PARITY_EN
    input  logic       parity_en,
    input  logic       parity_odd,
`endif
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        LOAD,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t     state;
    logic [3:0] tick_cnt;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic [1:0] stop_cnt;
    logic       bit8_q;
`ifdef UART_TX_PARITY_EN
    logic       par_en_q;
    logic       par_bit_q;
    logic [7:0] par_src;

    // Only the transmitted bits contribute to parity.
    assign par_src = bit8 ? fifo_data : {1'b0, fifo_data[6:0]};
`endif

    // Last of the 16 ticks that make up one bit period.
    logic bit_end;
    assign bit_end = baud_x16_tick && (tick_cnt == 4'hF);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            tick_cnt    <= 4'd0;
            shreg       <= 8'd0;
            bit_cnt     <= 3'd0;
            stop_cnt    <= 2'd0;
            bit8_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
`endif
            txd         <= 1'b1;
            fifo_read_n <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            tx_done     <= 1'b0;
            fifo_read_n <= 1'b1;
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (!fifo_empty) begin
                        // Strobe is registered so it is low during RD_REQ.
                        state       <= RD_REQ;
                        fifo_read_n <= 1'b0;
                        tx_busy     <= 1'b1;
                    end
                end
                RD_REQ:  state <= RD_WAIT;
                RD_WAIT: state <= LOAD;
                LOAD: begin
                    // FIFO data lands here, two clocks after the strobe.
                    shreg     <= fifo_data;
                    bit8_q    <= bit8;
`ifdef UART_TX_PARITY_EN
                    par_en_q  <= parity_en;
                    par_bit_q <= (^par_src) ^ parity_odd;
`endif
                    tick_cnt  <= 4'd0;
                    txd       <= 1'b0;
                    state     <= START;
                end
                START: begin
                    if (baud_x16_tick) tick_cnt <= tick_cnt + 4'd1;
                    if (bit_end) begin
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= 3'd0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_x16_tick) tick_cnt <= tick_cnt + 4'd1;
                    if (bit_end) begin
                        if (bit_cnt == (bit8_q ? 3'd7 : 3'd6)) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                txd   <= par_bit_q;
                                state <= PARITY;
                            end else begin
                                txd      <= 1'b1;
                                stop_cnt <= 2'd0;
                                state    <= STOP;
                            end
`else
                            txd      <= 1'b1;
                            stop_cnt <= 2'd0;
                            state    <= STOP;
`endif
                        end else begin
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_x16_tick) tick_cnt <= tick_cnt + 4'd1;
                    if (bit_end) begin
                        txd      <= 1'b1;
                        stop_cnt <= 2'd0;
                        state    <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_x16_tick) tick_cnt <= tick_cnt + 4'd1;
                    if (bit_end) begin
                        if (stop_cnt == 2'(STOP_BITS - 1)) begin
                            tx_done <= 1'b1;
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
